// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: control and status bundle between the fetch PC unit
// (slave) and the decode/execute/exception logic that steers it (master).
// The misalign signal exists only when PC_ALIGN_CHECK_EN is defined.
interface fetch_pc_unit_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) ();
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic            stall;
  logic            exc_valid;
  logic            jump_valid;
  logic [XLEN-1:0] jump_target;
  logic            call;
  logic            ret_valid;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus_inc;
  logic [CW-1:0]   ras_count;
  logic            ras_empty;
  logic            ras_underflow;
`ifdef PC_ALIGN_CHECK_EN
  logic            misalign;
`endif

  modport slave (
    input  stall, exc_valid, jump_valid, jump_target, call, ret_valid,
    output pc_out, pc_plus_inc, ras_count, ras_empty, ras_underflow
`ifdef PC_ALIGN_CHECK_EN
    , output misalign
`endif
  );

  modport master (
    output stall, exc_valid, jump_valid, jump_target, call, ret_valid,
    input  pc_out, pc_plus_inc, ras_count, ras_empty, ras_underflow
`ifdef PC_ALIGN_CHECK_EN
    , input misalign
`endif
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC register with prioritised next-PC selection
// (exception > stall > return > jump > sequential) and a circular
// return-address stack. Optional feature macro: PC_ALIGN_CHECK_EN, which
// rejects redirect targets whose low two bits are non-zero and raises a
// one-cycle misalign pulse instead.
module fetch_pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h0000_0010,
  parameter int              INC          = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input logic           clk,
  input logic           rst,
  fetch_pc_unit_if.slave bus
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);

`ifdef PC_ALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction
`endif

  logic [XLEN-1:0] pc_out_r;
  logic [XLEN-1:0] pc_plus_inc_s;
  logic [XLEN-1:0] pc_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt_s;
  logic [PW-1:0]   tos_r;       // next free slot; top entry sits one below
  logic [PW-1:0]   tos_nxt_s;
  logic [PW-1:0]   top_idx_s;
  logic            push_s;
  logic            empty_r;
  logic            uf_r;
  logic            uf_nxt_s;
  logic [XLEN-1:0] ras_mem_r [RAS_DEPTH];
`ifdef PC_ALIGN_CHECK_EN
  logic            mis_r;
  logic            mis_nxt_s;
`endif

  assign pc_plus_inc_s = pc_out_r + XLEN'(INC);
  assign top_idx_s     = tos_r - PW'(1);

  // Next-PC selection and RAS bookkeeping in priority order.
  always_comb begin
    pc_nxt_s  = pc_plus_inc_s;
    cnt_nxt_s = cnt_r;
    tos_nxt_s = tos_r;
    push_s    = 1'b0;
    uf_nxt_s  = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    mis_nxt_s = 1'b0;
`endif
    if (bus.exc_valid) begin
      pc_nxt_s = EXC_VECTOR;
    end else if (bus.stall) begin
      pc_nxt_s = pc_out_r;
    end else if (bus.ret_valid) begin
      if (cnt_r == CW'(0)) begin
        pc_nxt_s = EXC_VECTOR;
        uf_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r - CW'(1);
        tos_nxt_s = top_idx_s;
`ifdef PC_ALIGN_CHECK_EN
        if (is_misaligned(ras_mem_r[top_idx_s])) begin
          pc_nxt_s  = EXC_VECTOR;
          mis_nxt_s = 1'b1;
        end else begin
          pc_nxt_s = ras_mem_r[top_idx_s];
        end
`else
        pc_nxt_s = ras_mem_r[top_idx_s];
`endif
      end
    end else if (bus.jump_valid) begin
      if (bus.call) begin
        // A full stack keeps its count; the wrapped pointer overwrites the oldest entry.
        push_s    = 1'b1;
        tos_nxt_s = tos_r + PW'(1);
        cnt_nxt_s = (cnt_r == CW'(RAS_DEPTH)) ? cnt_r : (cnt_r + CW'(1));
      end else begin
        push_s = 1'b0;
      end
`ifdef PC_ALIGN_CHECK_EN
      if (is_misaligned(bus.jump_target)) begin
        pc_nxt_s  = EXC_VECTOR;
        mis_nxt_s = 1'b1;
      end else begin
        pc_nxt_s = bus.jump_target;
      end
`else
      pc_nxt_s = bus.jump_target;
`endif
    end else begin
      pc_nxt_s = pc_plus_inc_s;
    end
  end

  // PC, stack pointer/count and status pulses; reset clears all control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out_r <= RESET_VECTOR;
      cnt_r    <= CW'(0);
      tos_r    <= PW'(0);
      empty_r  <= 1'b1;
      uf_r     <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      mis_r    <= 1'b0;
`endif
    end else begin
      pc_out_r <= pc_nxt_s;
      cnt_r    <= cnt_nxt_s;
      tos_r    <= tos_nxt_s;
      empty_r  <= (cnt_nxt_s == CW'(0));
      uf_r     <= uf_nxt_s;
`ifdef PC_ALIGN_CHECK_EN
      mis_r    <= mis_nxt_s;
`endif
    end
  end

  // Return-address storage; contents are irrelevant after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      ras_mem_r[tos_r] <= pc_plus_inc_s;
    end
  end

  assign bus.pc_out        = pc_out_r;
  assign bus.pc_plus_inc   = pc_plus_inc_s;
  assign bus.ras_count     = cnt_r;
  assign bus.ras_empty     = empty_r;
  assign bus.ras_underflow = uf_r;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.misalign      = mis_r;
`endif
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Parametrised successor to the basic program counter: a fetch-stage PC register with prioritised next-PC selection, supporting sequential increment, stall, jump/branch redirect, exception vectoring and a circular return-address stack (RAS) for call/return. It sits at the front of the fetch stage, drives the instruction-memory address, and takes control inputs from decode/execute and the exception logic.

## Interface
- XLEN, 32, PC and target width in bits
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- EXC_VECTOR, 32'h0000_0010, PC value loaded on exception or RAS underflow
- INC, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC; blocks jump/call/ret and sequential update
- exc_valid  in  1  take exception: next PC = EXC_VECTOR
- jump_valid  in  1  redirect to jump_target
- jump_target  in  XLEN  redirect destination
- call  in  1  qualifier on jump_valid: also push pc_out+INC onto RAS
- ret_valid  in  1  pop RAS top and redirect there
- pc_out  out  XLEN  current PC (registered)
- pc_plus_inc  out  XLEN  pc_out+INC (combinational)
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
- ras_empty  out  1  ras_count==0
- ras_underflow  out  1  one-cycle registered pulse: ret with empty RAS

## Operation
- Next-PC priority, evaluated every cycle: rst > exc_valid > stall > ret_valid > jump_valid > sequential.
- exc_valid: pc_out <= EXC_VECTOR regardless of stall; RAS untouched; jump/call/ret that cycle ignored.
- stall (no exc): pc_out holds; RAS holds; all other controls ignored (producer must keep them asserted).
- ret_valid, RAS non-empty: pc_out <= top entry; ras_count decrements.
- ret_valid, RAS empty: pc_out <= EXC_VECTOR; ras_underflow=1 next cycle; count stays 0.
- ret_valid with jump_valid: ret wins; jump and call ignored.
- jump_valid: pc_out <= jump_target; if call, push pc_out+INC (pre-jump PC).
- call without jump_valid: ignored.
- Sequential: pc_out <= pc_out+INC.
- RAS is circular: push at full (count==RAS_DEPTH) overwrites oldest entry, count saturates at RAS_DEPTH; top pointer wraps mod RAS_DEPTH.
- Arithmetic: pc_out+INC computed in XLEN bits, wraps modulo 2^XLEN (e.g. 32'hFFFF_FFFC+4 = 0).

## Timing
- All state updates on rising clk; controls sampled at the edge, effect visible on pc_out the following cycle (1-cycle latency).
- pc_plus_inc follows pc_out combinationally, zero latency.
- rst asserted: immediately pc_out=RESET_VECTOR, ras_count=0, ras_empty=1, ras_underflow=0, RAS pointer=0; entry contents don't care.
- rst deasserted: first sequential update on the first rising edge with rst low.
- Reset mid-call/ret discards the RAS contents; no partial update.
- ras_underflow is high exactly one cycle per underflowing ret; back-to-back underflows give back-to-back pulses.

## Configuration
- PC_ALIGN_CHECK_EN defined: adds output misalign (1 bit, registered, reset 0). A jump_target or popped RAS entry with bits [1:0]≠0 is not taken; pc_out <= EXC_VECTOR and misalign pulses for one cycle; a call push still occurs. Underflow takes precedence when both apply.
- Not defined: no misalign port; targets loaded verbatim, low bits unchecked.

## Test plan
- Reset then free-run: rst high 2 cycles, release -> pc_out 0x0, 0x4, 0x8, 0xC on successive edges; ras_empty=1.
- Stall and exception: stall=1 at pc=0x8 for 3 cycles -> pc holds 0x8; exc_valid with stall=1 -> pc=0x10 next cycle.
- Call/return: at pc=0x20, jump_valid=1, call=1, target=0x100 -> pc=0x100, ras_count=1; later ret_valid -> pc=0x24, ras_count=0.
- RAS wrap: 5 nested calls from pcs 0x0,0x100,0x200,0x300,0x400 with RAS_DEPTH=4 -> count saturates at 4; 4 rets return 0x404,0x304,0x204,0x104; 5th ret -> pc=0x10, ras_underflow one-cycle pulse.
- Priority collisions: ret_valid+jump_valid same cycle -> ret target taken, no push; exc_valid+ret_valid -> pc=0x10, ras_count unchanged.
- Wrap and alignment: pc=0xFFFF_FFFC sequential -> 0x0; with PC_ALIGN_CHECK_EN, jump_target=0x102 -> pc=0x10, misalign pulse.
